// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side bundles for the direct-mapped I-cache.
// The cache is the slave of fetch and the master of the memory bus.
interface icache_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              flush;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  modport master (
    output req_valid, req_addr, flush,
    input  instr, instr_valid, hit_cnt, miss_cnt
  );
  modport slave (
    input  req_valid, req_addr, flush,
    output instr, instr_valid, hit_cnt, miss_cnt
  );
endinterface

interface icache_mem_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );
  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with line refill,
// whole-cache invalidate and hit/miss counters.
module icache_dm #(
  parameter int LINES  = 64,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  icache_fetch_if.slave  fe,
  icache_mem_if.master   mem
);
  localparam int WB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int OB = WB + 2;
  localparam int TW = ADDR_W - IB - OB;

  typedef enum logic [1:0] {IDLE, MREQ, REFILL} state_e;
  typedef logic [TW-1:0] tag_t;
  typedef logic [IB-1:0] idx_t;
  typedef logic [WB-1:0] word_t;

  logic [31:0]      data_q [LINES][WORDS];
  tag_t             tag_q  [LINES];
  logic [LINES-1:0] valid_q, valid_d;

  state_e      state_q, state_d;
  idx_t        idx_q, idx_d;
  tag_t        ltag_q, ltag_d;
  word_t       beat_q, beat_d;
  logic        fpend_q, fpend_d;
  logic [31:0] hit_q, hit_d;
  logic [31:0] miss_q, miss_d;

  word_t req_word;
  idx_t  req_idx;
  tag_t  req_tag;
  logic  hit;
  logic  iv;
  logic  fill_we;
  logic  last;
  logic  unused_addr_lsb;

  assign req_word = fe.req_addr[OB-1:2];
  assign req_idx  = fe.req_addr[OB+IB-1:OB];
  assign req_tag  = fe.req_addr[ADDR_W-1:OB+IB];
  assign unused_addr_lsb = ^fe.req_addr[1:0];

  assign hit = valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign iv  = (state_q == IDLE) & fe.req_valid & hit & ~fe.flush;

  assign fill_we = (state_q == REFILL) & mem.mem_resp_valid;
  assign last    = fill_we & (beat_q == word_t'(WORDS - 1));

  assign fe.instr       = data_q[req_idx][req_word];
  assign fe.instr_valid = iv;
  assign fe.hit_cnt     = hit_q;
  assign fe.miss_cnt    = miss_q;
  assign mem.mem_req_addr = {ltag_q, idx_q, {OB{1'b0}}};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ltag_d  = ltag_q;
    beat_d  = beat_q;
    fpend_d = fpend_q;
    valid_d = valid_q;
    miss_d  = miss_q;
    hit_d   = hit_q + {31'd0, iv};
    mem.mem_req_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fe.flush) begin
          valid_d = '0;
        end else if (fe.req_valid && !hit) begin
          idx_d   = req_idx;
          ltag_d  = req_tag;
          beat_d  = '0;
          miss_d  = miss_q + 32'd1;
          state_d = MREQ;
        end
      end
      MREQ: begin
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) state_d = REFILL;
      end
      REFILL: begin
        if (fill_we) beat_d = beat_q + word_t'(1);
        if (last) begin
          state_d = IDLE;
          fpend_d = 1'b0;
          if (!fpend_q) valid_d[idx_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush landing on the final beat must still leave the line invalid.
    if (fe.flush && state_q != IDLE) begin
      valid_d = '0;
      fpend_d = ~last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      idx_q   <= '0;
      ltag_q  <= '0;
      beat_q  <= '0;
      fpend_q <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ltag_q  <= ltag_d;
      beat_q  <= beat_d;
      fpend_q <= fpend_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we && !reset) data_q[idx_q][beat_q] <= mem.mem_resp_data;
    if (last && !reset)    tag_q[idx_q] <= ltag_q;
  end
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed refill/flush/reset
// sequences, a lookup vector table and a randomized model run.
module tb_icache_dm;
  localparam int LINES = 64;
  localparam int WORDS = 4;
  localparam int LB    = WORDS * 4;

  typedef logic [31:0] beats_t [WORDS];
  typedef struct {
    logic        rv;
    logic        fl;
    logic [31:0] addr;
    logic        exp_iv;
    logic [31:0] exp_instr;
  } vec_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  icache_fetch_if #(.ADDR_W(32)) fe();
  icache_mem_if   #(.ADDR_W(32)) mi();

  icache_dm #(.LINES(LINES), .WORDS(WORDS), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .fe    (fe),
    .mem   (mi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5EED_0000;
  endfunction

  task automatic do_reset();
    fe.req_valid = 1'b0;
    fe.req_addr  = '0;
    fe.flush     = 1'b0;
    mi.mem_req_ready  = 1'b0;
    mi.mem_resp_valid = 1'b0;
    mi.mem_resp_data  = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called just after a negedge with the cache idle; returns just after
  // the negedge that follows the final beat.
  task automatic do_miss(input logic [31:0] a, input beats_t d,
                         input int rdy_dly, input bit gaps,
                         input int fl_beat);
    bit pat [7];
    int k;
    int c;
    logic v;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    fe.req_valid = 1'b1;
    fe.req_addr  = a;
    fe.flush     = 1'b0;
    #1;
    chk("miss_iv", {31'd0, fe.instr_valid}, 32'd0);
    chk("idle_mreq", {31'd0, mi.mem_req_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("mreq_valid", {31'd0, mi.mem_req_valid}, 32'd1);
    chk("mreq_addr", mi.mem_req_addr, a & ~32'(LB - 1));
    for (int i = 0; i < rdy_dly; i++) begin
      fe.req_addr = a ^ 32'h100;
      mi.mem_resp_valid = 1'b1;
      mi.mem_resp_data  = 32'hBAD0_0000 + 32'(i);
      @(negedge clk);
      #1;
      chk("bp_valid", {31'd0, mi.mem_req_valid}, 32'd1);
      chk("bp_addr", mi.mem_req_addr, a & ~32'(LB - 1));
      chk("bp_iv", {31'd0, fe.instr_valid}, 32'd0);
    end
    fe.req_addr = a;
    mi.mem_resp_valid = 1'b0;
    mi.mem_req_ready  = 1'b1;
    @(negedge clk);
    mi.mem_req_ready = 1'b0;
    k = 0;
    c = 0;
    while (k < WORDS) begin
      v = gaps ? pat[c % 7] : 1'b1;
      mi.mem_resp_valid = v;
      mi.mem_resp_data  = v ? d[k] : 32'hDEAD_BEEF;
      fe.flush = v && (k == fl_beat);
      #1;
      chk("refill_mreq", {31'd0, mi.mem_req_valid}, 32'd0);
      chk("refill_iv", {31'd0, fe.instr_valid}, 32'd0);
      @(negedge clk);
      if (v) k++;
      c++;
    end
    mi.mem_resp_valid = 1'b0;
    fe.flush = 1'b0;
  endtask

  beats_t dA, dB, dC, dD, dE, dF, dG, dH;
  vec_t   tbl [9];

  // Randomized-run reference state: which line address each set holds.
  bit          own_v    [LINES];
  logic [31:0] own_line [LINES];

  initial begin
    int          eh;
    int          ph;
    int          nb;
    bit          fpend;
    int unsigned mh;
    int unsigned mm;
    logic [31:0] base;
    logic [31:0] addr;
    logic [31:0] line;
    logic [31:0] idx;
    logic        rv, fl, rdy, rsp, res, e_iv;

    tests = 0;
    fails = 0;
    dA = '{32'h11, 32'h22, 32'h33, 32'h44};
    dB = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    dC = '{32'hB100_0000, 32'hB100_0001, 32'hB100_0002, 32'hB100_0003};
    dD = '{32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003};
    dE = '{32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003};
    dF = '{32'hF000_0000, 32'hF000_0001, 32'hF000_0002, 32'hF000_0003};
    dG = '{32'h0400_0000, 32'h0400_0001, 32'h0400_0002, 32'h0400_0003};
    dH = '{32'h7700_0000, 32'h7700_0001, 32'h7700_0002, 32'h7700_0003};

    tbl[0] = '{1'b1, 1'b0, 32'h0,  1'b1, dD[0]};
    tbl[1] = '{1'b1, 1'b0, 32'hC,  1'b1, dD[3]};
    tbl[2] = '{1'b0, 1'b0, 32'h4,  1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 32'h4,  1'b1, dD[1]};
    tbl[4] = '{1'b1, 1'b0, 32'h8,  1'b1, dD[2]};
    tbl[5] = '{1'b1, 1'b0, 32'h3,  1'b1, dD[0]};
    tbl[6] = '{1'b1, 1'b0, 32'hB,  1'b1, dD[2]};
    tbl[7] = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
    tbl[8] = '{1'b1, 1'b0, 32'h8,  1'b0, 32'h0};

    // Reset state
    do_reset();
    reset = 1'b1;
    fe.req_valid = 1'b1;
    #1;
    chk("rst_iv", {31'd0, fe.instr_valid}, 32'd0);
    chk("rst_mreq", {31'd0, mi.mem_req_valid}, 32'd0);
    chk("rst_hit", fe.hit_cnt, 32'd0);
    chk("rst_miss", fe.miss_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Cold miss then same-line hit
    do_miss(32'h0, dA, 0, 1'b0, -1);
    #1;
    chk("cold_iv", {31'd0, fe.instr_valid}, 32'd1);
    chk("cold_instr", fe.instr, 32'h11);
    @(negedge clk);
    fe.req_addr = 32'h8;
    #1;
    chk("hit8_iv", {31'd0, fe.instr_valid}, 32'd1);
    chk("hit8_instr", fe.instr, 32'h33);
    @(negedge clk);
    fe.req_valid = 1'b0;
    #1;
    chk("t1_hits", fe.hit_cnt, 32'd2);
    chk("t1_miss", fe.miss_cnt, 32'd1);

    // Conflict on index 0
    do_miss(32'h400, dG, 0, 1'b0, -1);
    #1;
    chk("conf_instr", fe.instr, dG[0]);
    do_miss(32'h0, dB, 0, 1'b0, -1);
    #1;
    chk("conf_iv", {31'd0, fe.instr_valid}, 32'd1);
    chk("conf_instr0", fe.instr, dB[0]);
    chk("conf_miss", fe.miss_cnt, 32'd3);

    // Request backpressure; fetch address wanders while stalled
    do_miss(32'h24, dC, 5, 1'b0, -1);
    #1;
    chk("bp_hit_iv", {31'd0, fe.instr_valid}, 32'd1);
    chk("bp_hit_instr", fe.instr, dC[1]);

    // Beat gaps then a table of lookups ending in a flush
    do_reset();
    do_miss(32'h0, dD, 1, 1'b1, -1);
    eh = 0;
    foreach (tbl[i]) begin
      fe.req_valid = tbl[i].rv;
      fe.flush     = tbl[i].fl;
      fe.req_addr  = tbl[i].addr;
      #1;
      chk($sformatf("tbl%0d_iv", i), {31'd0, fe.instr_valid},
          {31'd0, tbl[i].exp_iv});
      if (tbl[i].exp_iv) begin
        chk($sformatf("tbl%0d_instr", i), fe.instr, tbl[i].exp_instr);
        eh++;
      end
      @(negedge clk);
      fe.flush = 1'b0;
      #1;
      chk($sformatf("tbl%0d_hits", i), fe.hit_cnt, 32'(eh));
      if (i == 8) chk("tbl_flush_mreq", {31'd0, mi.mem_req_valid}, 32'd1);
      if (i == 8) begin
        mi.mem_req_ready = 1'b1;
        @(negedge clk);
        mi.mem_req_ready = 1'b0;
        for (int b = 0; b < WORDS; b++) begin
          mi.mem_resp_valid = 1'b1;
          mi.mem_resp_data  = dH[b];
          @(negedge clk);
        end
        mi.mem_resp_valid = 1'b0;
      end
    end
    #1;
    chk("refetch_instr", fe.instr, dH[2]);

    // Flush in IDLE already happened; flush during refill beat 2
    fe.req_valid = 1'b1;
    fe.req_addr  = 32'h0;
    fe.flush     = 1'b1;
    @(negedge clk);
    fe.flush = 1'b0;
    do_miss(32'h0, dE, 0, 1'b0, 2);
    #1;
    chk("fl_refill_iv", {31'd0, fe.instr_valid}, 32'd0);
    do_miss(32'h0, dF, 0, 1'b0, -1);
    #1;
    chk("fl_after_iv", {31'd0, fe.instr_valid}, 32'd1);
    chk("fl_after_instr", fe.instr, dF[0]);

    // Reset in the middle of a refill
    fe.req_addr = 32'h50;
    @(negedge clk);
    mi.mem_req_ready = 1'b1;
    @(negedge clk);
    mi.mem_req_ready  = 1'b0;
    mi.mem_resp_valid = 1'b1;
    mi.mem_resp_data  = 32'h1;
    @(negedge clk);
    mi.mem_resp_data  = 32'h2;
    @(negedge clk);
    reset = 1'b1;
    mi.mem_resp_data = 32'h3;
    @(negedge clk);
    reset = 1'b0;
    mi.mem_resp_valid = 1'b0;
    fe.req_addr = 32'h0;
    #1;
    chk("mr_mreq", {31'd0, mi.mem_req_valid}, 32'd0);
    chk("mr_iv", {31'd0, fe.instr_valid}, 32'd0);
    chk("mr_hit", fe.hit_cnt, 32'd0);
    chk("mr_miss", fe.miss_cnt, 32'd0);
    do_miss(32'h0, dA, 0, 1'b0, -1);
    #1;
    chk("mr_fresh_instr", fe.instr, dA[0]);
    chk("mr_fresh_miss", fe.miss_cnt, 32'd1);

    // Randomized run against a line-ownership model
    do_reset();
    foreach (own_v[i]) own_v[i] = 1'b0;
    ph = 0; nb = 0; fpend = 1'b0; mh = 0; mm = 0;
    base = '0; addr = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rv  = ($urandom_range(0, 9) != 0);
      fl  = ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      rsp = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0)
        addr = 32'($urandom_range(0, 3)) * 32'(LINES * LB)
             + 32'($urandom_range(0, 7)) * 32'(LB)
             + 32'($urandom_range(0, WORDS - 1)) * 32'd4
             + (($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'h0);
      fe.req_valid = rv;
      fe.req_addr  = addr;
      fe.flush     = fl;
      mi.mem_req_ready  = rdy;
      mi.mem_resp_valid = rsp;
      mi.mem_resp_data  = (ph == 2 && rsp) ? mem_word(base + 32'(nb * 4))
                                          : $urandom;
      #1;
      line = addr & ~32'(LB - 1);
      idx  = (addr / LB) % LINES;
      res  = own_v[idx] && (own_line[idx] == line);
      e_iv = (ph == 0) && rv && res && !fl;
      chk("rnd_iv", {31'd0, fe.instr_valid}, {31'd0, e_iv});
      if (e_iv) chk("rnd_instr", fe.instr, mem_word(addr & ~32'd3));
      chk("rnd_mreq", {31'd0, mi.mem_req_valid}, {31'd0, ph == 1});
      if (ph == 1) chk("rnd_maddr", mi.mem_req_addr, base);
      chk("rnd_hits", fe.hit_cnt, mh);
      chk("rnd_miss", fe.miss_cnt, mm);
      if (e_iv) mh++;
      if (fl) foreach (own_v[i]) own_v[i] = 1'b0;
      if (ph == 0) begin
        if (!fl && rv && !res) begin
          base = line; ph = 1; nb = 0; fpend = 1'b0; mm++;
        end
      end else if (ph == 1) begin
        if (fl) fpend = 1'b1;
        if (rdy) ph = 2;
      end else begin
        if (fl) fpend = 1'b1;
        if (rsp) begin
          nb++;
          if (nb == WORDS) begin
            if (!fpend) begin
              own_v[(base / LB) % LINES]    = 1'b1;
              own_line[(base / LB) % LINES] = base;
            end
            ph = 0;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
